// File: rtl/cpu_pkg.sv
// Shared opcode, phase and sizing definitions for the CPU sequencer.
package cpu_pkg;

    localparam int unsigned OPCODE_W    = 4;
    localparam int unsigned PHASE_W     = 3;
    localparam int unsigned STACK_DEPTH = 8;
    localparam int unsigned DEPTH_W     = 4;
    localparam int unsigned COUNT_W     = 16;

    localparam logic [OPCODE_W-1:0] OP_STA = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_JMP = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_STP = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_LDA = 4'b0101;
    localparam logic [OPCODE_W-1:0] OP_JMS = 4'b0110;
    localparam logic [OPCODE_W-1:0] OP_BBL = 4'b0111;
    localparam logic [OPCODE_W-1:0] OP_LDR = 4'b1110;

    localparam logic [PHASE_W-1:0] PH_NONE  = 3'b000;
    localparam logic [PHASE_W-1:0] PH_FETCH = 3'b001;
    localparam logic [PHASE_W-1:0] PH_EXEC1 = 3'b010;
    localparam logic [PHASE_W-1:0] PH_EXEC2 = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FWAIT,
        S_FETCH,
        S_PRE,
        S_EXEC1,
        S_EXEC2,
        S_FAULT
    } seq_state_e;

    // Opcodes that need the data memory before they may execute.
    function automatic logic is_dmem_op(input logic [OPCODE_W-1:0] op);
        return (op == OP_STA) || (op == OP_LDA) || (op == OP_LDR);
    endfunction

    // One-hot decoder phase seen while in a given state.
    function automatic logic [PHASE_W-1:0] phase_of(input seq_state_e s);
        case (s)
            S_FETCH: return PH_FETCH;
            S_EXEC1: return PH_EXEC1;
            S_EXEC2: return PH_EXEC2;
            default: return PH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/seq_depth_counter.sv
// Return-stack occupancy counter with registered full/empty flags.
module seq_depth_counter
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               dec,
    output logic [DEPTH_W-1:0] count,
    output logic               full,
    output logic               empty
);

    logic [DEPTH_W-1:0] count_nxt;

    // Saturating next occupancy; simultaneous inc/dec cancels.
    always_comb begin
        count_nxt = count;
        if (inc && !dec && (count != DEPTH_W'(STACK_DEPTH))) begin
            count_nxt = count + DEPTH_W'(1);
        end else if (dec && !inc && (count != '0)) begin
            count_nxt = count - DEPTH_W'(1);
        end
    end

    // Occupancy and flags registered together so they never disagree.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_W'(STACK_DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction phase sequencer: fetch / pre-check / exec1 / exec2 with stalls,
// halt handling, return-stack bounds checking and retired-instruction count.
module cpu_sequencer
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                halt_req,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    input  logic [OPCODE_W-1:0] inst,
    output logic [PHASE_W-1:0]  state,
    output logic                halted,
    output logic                fault,
    output logic [DEPTH_W-1:0]  stack_depth,
    output logic [COUNT_W-1:0]  instr_count
);

    seq_state_e seq_state;
    seq_state_e seq_nxt;
    logic       halt_pend;
    logic       depth_full;
    logic       depth_empty;
    logic       push;
    logic       pop;

    assign push = (seq_state == S_EXEC1) && (inst == OP_JMS);
    assign pop  = (seq_state == S_EXEC1) && (inst == OP_BBL);

    seq_depth_counter u_depth (
        .clk   (clk),
        .reset (reset),
        .inc   (push),
        .dec   (pop),
        .count (stack_depth),
        .full  (depth_full),
        .empty (depth_empty)
    );

    // Next-state decision; a halt seen in EXEC2 itself still stops after retire.
    always_comb begin
        seq_nxt = seq_state;
        case (seq_state)
            S_IDLE: begin
                if (run && !halt_req) begin
                    seq_nxt = imem_ready ? S_FETCH : S_FWAIT;
                end
            end
            S_FWAIT: begin
                if (imem_ready) begin
                    seq_nxt = S_FETCH;
                end
            end
            S_FETCH: seq_nxt = S_PRE;
            S_PRE: begin
                if (((inst == OP_JMS) && depth_full) || ((inst == OP_BBL) && depth_empty)) begin
                    seq_nxt = S_FAULT;
                end else if (!(is_dmem_op(inst) && !dmem_ready)) begin
                    seq_nxt = S_EXEC1;
                end
            end
            S_EXEC1: seq_nxt = S_EXEC2;
            S_EXEC2: begin
                if (halt_pend || halt_req || (inst == OP_STP)) begin
                    seq_nxt = S_IDLE;
                end else begin
                    seq_nxt = imem_ready ? S_FETCH : S_FWAIT;
                end
            end
            S_FAULT: seq_nxt = S_FAULT;
            default: seq_nxt = S_IDLE;
        endcase
    end

    // State, registered phase/status outputs, halt latch and retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            seq_state   <= S_IDLE;
            state       <= PH_NONE;
            halted      <= 1'b1;
            fault       <= 1'b0;
            halt_pend   <= 1'b0;
            instr_count <= '0;
        end else begin
            seq_state <= seq_nxt;
            state     <= phase_of(seq_nxt);
            halted    <= (seq_nxt == S_IDLE);
            fault     <= (seq_nxt == S_FAULT);
            if (seq_nxt == S_IDLE) begin
                halt_pend <= 1'b0;
            end else if (halt_req && (seq_state != S_IDLE) && (seq_state != S_FAULT)) begin
                halt_pend <= 1'b1;
            end
            if (seq_state == S_EXEC2) begin
                instr_count <= instr_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high. Ports: clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 run  input  1  start request, sampled only in IDLE.
REQ-005 halt_req  input  1  halt request, sampled every cycle.
REQ-006 imem_ready  input  1  instruction memory can complete a fetch this cycle.
REQ-007 dmem_ready  input  1  data memory can service STA/LDA/LDR this cycle.
REQ-008 inst  input  4  opcode; valid and stable from the cycle after FETCH through EXEC2.
REQ-009 state  output  3  one-hot phase to the decoder: bit0 fetch, bit1 exec1, bit2 exec2, 000 otherwise.
REQ-010 halted  output  1  high in IDLE.
REQ-011 fault  output  1  high in FAULT.
REQ-012 stack_depth  output  4  return-stack occupancy, 0..8.
REQ-013 instr_count  output  16  count of retired instructions.

Function
REQ-014 Internal states SHALL be IDLE, FWAIT, FETCH, PRE, EXEC1, EXEC2 and FAULT; state output is 001/010/100 only in FETCH/EXEC1/EXEC2, and 000 otherwise.
REQ-015 IDLE SHALL go to FETCH if run=1, halt_req=0 and imem_ready=1; to FWAIT if run=1, halt_req=0 and imem_ready=0; otherwise stay.
REQ-016 FWAIT SHALL go to FETCH when imem_ready=1, else stay.
REQ-017 FETCH SHALL last exactly one cycle, then go to PRE.
REQ-018 PRE SHALL go to FAULT if inst=JMS (0110) and stack_depth=8, or if inst=BBL (0111) and stack_depth=0.
REQ-019 Otherwise, PRE SHALL hold while inst is STA (0000), LDA (0101) or LDR (1110) and dmem_ready=0; else it goes to EXEC1.
REQ-020 EXEC1 SHALL last one cycle, then go to EXEC2.
REQ-021 In EXEC1, stack_depth SHALL increment by 1 for JMS and decrement by 1 for BBL, and is otherwise unchanged.
REQ-022 EXEC2 SHALL last one cycle; instr_count increments by 1 there, wrapping FFFF->0000.
REQ-023 After EXEC2 the next state SHALL be IDLE if halt_pend=1 or inst=STP (0100); otherwise FETCH if imem_ready=1, else FWAIT.
REQ-024 halt_pend SHALL set on halt_req=1 in any non-IDLE, non-FAULT state and clear on entry to IDLE; an instruction in flight always completes through EXEC2.
REQ-025 halt_req=1 in IDLE SHALL override run.
REQ-026 FAULT SHALL be absorbing until reset: state=000, counters frozen.
REQ-027 Minimum instruction latency SHALL be 4 cycles (FETCH, PRE, EXEC1, EXEC2), with back-to-back FETCH the cycle after EXEC2 when imem_ready=1.
REQ-028 Each of fetch, exec1 and exec2 SHALL be asserted for exactly one cycle per instruction regardless of stalls, so decoder pc_inc/push/pop/WrEn fire exactly once.

Reset
REQ-029 On reset=1 at a clk edge, the block SHALL enter IDLE: state=000, halted=1, fault=0, stack_depth=0, instr_count=0, halt_pend=0.
REQ-030 Reset SHALL take priority over every transition, including mid-instruction and in FAULT.

Structure
REQ-031 Shared package cpu_pkg SHALL hold the opcode constants (STA, JMP, STP, LDA, JMS, BBL, LDR), the one-hot phase constants and STACK_DEPTH=8.
REQ-032 Return-stack occupancy SHALL be one sub-module, seq_depth_counter, with inc, dec, full and empty.
REQ-033 The sequencer FSM SHALL be a single registered next-state process with registered outputs.

Verification
REQ-034 Reset, run=1, imem_ready=dmem_ready=1, inst=JMP -> state 001,000,010,100 repeating every 4 cycles; instr_count=1 after the first EXEC2.
REQ-035 imem_ready=0 for 3 cycles after EXEC2 -> 3 FWAIT cycles with state=000, then one fetch pulse; no duplicate fetch.
REQ-036 inst=LDA, dmem_ready low 2 cycles -> PRE held 2 extra cycles, then exec1 and exec2 once each.
REQ-037 9 consecutive JMS from depth 0 -> depth reaches 8, 9th JMS enters FAULT with fault=1 and no exec1 pulse; BBL at depth 0 after reset -> FAULT.
REQ-038 halt_req pulsed during EXEC1, and separately inst=STP -> EXEC2 completes, halted=1 next cycle; run with halt_req=1 in IDLE -> stays IDLE.
REQ-039 reset asserted in EXEC1 with depth=3, count=0x00FF -> next cycle IDLE, depth=0, count=0; count wraps 0xFFFF->0x0000 on retire.
